// File: rtl/flu_issue_scheduler_pkg.sv
// Shared types for the FLU issue scheduler: unit classes, FSM states and latency bound.
// Imported by the scheduler top, its interface and the bench.
package flu_issue_scheduler_pkg;

  localparam int unsigned MAX_MUL_LATENCY = 4;

  typedef enum logic [2:0] {
    FLU_ALU    = 3'd0,
    FLU_BRANCH = 3'd1,
    FLU_CSR    = 3'd2,
    FLU_MUL    = 3'd3,
    FLU_DIV    = 3'd4,
    FLU_OTHER  = 3'd5
  } flu_class_t;

  typedef enum logic {
    SCHED_IDLE     = 1'b0,
    SCHED_DIV_BUSY = 1'b1
  } flu_sched_state_t;

endpackage

// File: rtl/flu_issue_scheduler_if.sv
// Issue-head handshake, unit readiness and per-unit execute strobes around the FLU scheduler.
// master = issue/execute environment, slave = scheduler.
interface flu_issue_scheduler_if;
  import flu_issue_scheduler_pkg::*;

  logic       issue_valid;
  flu_class_t issue_fu;
  logic       issue_ready;
  logic       csr_ready;
  logic       mult_ready;
  logic       div_done;
  logic       alu_valid;
  logic       branch_valid;
  logic       csr_valid;
  logic       mult_valid;

  modport master (
    output issue_valid, issue_fu, csr_ready, mult_ready, div_done,
    input  issue_ready, alu_valid, branch_valid, csr_valid, mult_valid
  );

  modport slave (
    input  issue_valid, issue_fu, csr_ready, mult_ready, div_done,
    output issue_ready, alu_valid, branch_valid, csr_valid, mult_valid
  );

endinterface

// File: rtl/flu_wb_reservation.sv
// Writeback reservation shift register: bit i set means a mult owns the FLU port i cycles from now.
// New reservations enter at the top bit; flush clears the whole table.
module flu_wb_reservation #(
  parameter int unsigned Latency = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               set_i,
  output logic [Latency-1:0] res_o
);

  logic [Latency-1:0] res_q, res_d;

  always_comb begin
    res_d              = res_q >> 1;
    res_d[Latency-1]   = set_i;
    if (flush_i) begin
      res_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/flu_issue_scheduler.sv
// Grants issue only when the result cannot collide on the shared FLU writeback port; decision is combinational.
// Optional FLU_SCHED_PERF_EN adds a saturating collision-stall counter on perf_stall_o.
module flu_issue_scheduler
  import flu_issue_scheduler_pkg::*;
#(
  parameter int unsigned MulLatency = 1,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  flu_issue_scheduler_if.slave  flu_if,
  output logic                  div_busy_o,
  output logic [CntWidth-1:0]   perf_stall_o
);

  flu_sched_state_t      state_q, state_d;
  logic [MulLatency-1:0] res_q;
  logic                  idle;
  logic                  hazard;
  logic                  class_ready;
  logic                  issue_ready;
  logic                  fire;

  flu_wb_reservation #(
    .Latency (MulLatency)
  ) u_res (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .set_i   (fire && flu_if.issue_fu == FLU_MUL),
    .res_o   (res_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SCHED_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCHED_IDLE:     if (fire && flu_if.issue_fu == FLU_DIV) state_d = SCHED_DIV_BUSY;
      SCHED_DIV_BUSY: if (flu_if.div_done || flush_i)         state_d = SCHED_IDLE;
      default:        state_d = SCHED_IDLE;
    endcase
  end

  // hazard marks stalls owed to the writeback port itself; csr/mult readiness is separate.
  always_comb begin
    idle        = (state_q == SCHED_IDLE);
    hazard      = 1'b0;
    class_ready = 1'b1;
    case (flu_if.issue_fu)
      FLU_ALU, FLU_BRANCH: begin
        hazard      = !idle || res_q[0];
        class_ready = !hazard;
      end
      FLU_CSR: begin
        hazard      = !idle || res_q[0];
        class_ready = !hazard && flu_if.csr_ready;
      end
      FLU_MUL: begin
        hazard      = !idle;
        class_ready = !hazard && flu_if.mult_ready;
      end
      FLU_DIV: begin
        hazard      = !idle || (|res_q);
        class_ready = !hazard && flu_if.mult_ready;
      end
      default: begin
        hazard      = 1'b0;
        class_ready = 1'b1;
      end
    endcase
    issue_ready         = class_ready && !flush_i && !rst_i;
    fire                = flu_if.issue_valid && issue_ready;
    flu_if.issue_ready  = issue_ready;
    flu_if.alu_valid    = fire && flu_if.issue_fu == FLU_ALU;
    flu_if.branch_valid = fire && flu_if.issue_fu == FLU_BRANCH;
    flu_if.csr_valid    = fire && flu_if.issue_fu == FLU_CSR;
    flu_if.mult_valid   = fire && (flu_if.issue_fu == FLU_MUL || flu_if.issue_fu == FLU_DIV);
    div_busy_o          = !idle;
  end

`ifdef FLU_SCHED_PERF_EN
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flu_if.issue_valid && hazard && !flush_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_o = stall_cnt_q;
`else
  assign perf_stall_o = '0;
`endif

`ifndef SYNTHESIS
  div_done_only_when_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    flu_if.div_done |-> (state_q == SCHED_DIV_BUSY));
`endif

endmodule

// File: tb/tb_flu_issue_scheduler.sv
// Scenario bench for the FLU issue scheduler with MulLatency 1 (dut1) and 2 (dut2).
module tb_flu_issue_scheduler;
  import flu_issue_scheduler_pkg::*;

  typedef struct packed {
    logic       s;
    logic       r;
    logic       v;
    flu_class_t fu;
    logic       cr;
    logic       mr;
    logic       dd;
    logic       fl;
    logic [5:0] e;
  } row_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       sel;
  logic       iv;
  flu_class_t fu;
  logic       crdy;
  logic       mrdy;
  logic       dd;
  logic       busy1, busy2;
  logic [31:0] perf1, perf2;
  logic [5:0] obs1, obs2, got, exp_v;
  logic [5:0] expq[$];
  int         n_cmp;
  int         n_err;

  flu_issue_scheduler_if u_if1();
  flu_issue_scheduler_if u_if2();

  assign u_if1.issue_valid = iv & ~sel;
  assign u_if1.issue_fu    = fu;
  assign u_if1.csr_ready   = crdy;
  assign u_if1.mult_ready  = mrdy;
  assign u_if1.div_done    = dd & ~sel;
  assign u_if2.issue_valid = iv & sel;
  assign u_if2.issue_fu    = fu;
  assign u_if2.csr_ready   = crdy;
  assign u_if2.mult_ready  = mrdy;
  assign u_if2.div_done    = dd & sel;

  flu_issue_scheduler #(.MulLatency(1), .CntWidth(32)) dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .flu_if       (u_if1),
    .div_busy_o   (busy1),
    .perf_stall_o (perf1)
  );

  flu_issue_scheduler #(.MulLatency(2), .CntWidth(32)) dut2 (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .flu_if       (u_if2),
    .div_busy_o   (busy2),
    .perf_stall_o (perf2)
  );

  // Observed vector: {issue_ready, alu, branch, csr, mult, div_busy}
  assign obs1 = {u_if1.issue_ready, u_if1.alu_valid, u_if1.branch_valid,
                 u_if1.csr_valid, u_if1.mult_valid, busy1};
  assign obs2 = {u_if2.issue_ready, u_if2.alu_valid, u_if2.branch_valid,
                 u_if2.csr_valid, u_if2.mult_valid, busy2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(logic s, logic r, logic v, flu_class_t f, logic cr,
                              logic mr, logic d, logic fl, logic [5:0] e);
    row_t x;
    x.s = s; x.r = r; x.v = v; x.fu = f; x.cr = cr; x.mr = mr; x.dd = d; x.fl = fl; x.e = e;
    return x;
  endfunction

  task automatic apply(input row_t x);
    sel = x.s; rst = x.r; iv = x.v; fu = x.fu;
    crdy = x.cr; mrdy = x.mr; dd = x.dd; flush = x.fl;
    expq.push_back(x.e);
  endtask

  task automatic test_reset();
    row_t rows [4];
    rst = 1'b1; iv = 1'b1; fu = FLU_ALU;
    repeat (2) @(posedge clk);
    #1;
    rows = '{mk(0,1,1,FLU_ALU,1,1,0,0,6'b000000), mk(1,1,1,FLU_ALU,1,1,0,0,6'b000000),
             mk(0,0,0,FLU_ALU,1,1,0,0,6'b100000), mk(1,0,0,FLU_ALU,1,1,0,0,6'b100000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL reset cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (perf1 !== 32'd0 || perf2 !== 32'd0) begin
      $display("FAIL reset_perf got=%0d/%0d exp=0", perf1, perf2); n_err++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_l1();
    row_t rows [4];
    rows = '{mk(0,0,1,FLU_MUL,1,1,0,0,6'b100010), mk(0,0,1,FLU_ALU,1,1,0,0,6'b000000),
             mk(0,0,1,FLU_ALU,1,1,0,0,6'b110000), mk(0,0,0,FLU_ALU,1,1,0,0,6'b100000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL mul_l1 cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back_l2();
    row_t rows [7];
    rows = '{mk(1,0,1,FLU_MUL,1,1,0,0,6'b100010), mk(1,0,1,FLU_MUL,1,1,0,0,6'b100010),
             mk(1,0,1,FLU_ALU,1,1,0,0,6'b000000), mk(1,0,1,FLU_ALU,1,1,0,0,6'b000000),
             mk(1,0,1,FLU_ALU,1,1,0,0,6'b110000), mk(1,0,1,FLU_BRANCH,1,1,0,0,6'b101000),
             mk(1,0,1,FLU_CSR,1,1,0,0,6'b100100)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL b2b_l2 cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div();
    row_t rows [8];
    rows = '{mk(0,0,1,FLU_DIV,1,1,0,0,6'b100010), mk(0,0,1,FLU_ALU,1,1,0,0,6'b000001),
             mk(0,0,1,FLU_OTHER,1,1,0,0,6'b100001), mk(0,0,1,FLU_MUL,1,1,0,0,6'b000001),
             mk(0,0,1,FLU_ALU,1,1,0,0,6'b000001), mk(0,0,1,FLU_ALU,1,1,1,0,6'b000001),
             mk(0,0,1,FLU_ALU,1,1,0,0,6'b110000), mk(0,0,0,FLU_ALU,1,1,0,0,6'b100000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL div cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    row_t rows [8];
    rows = '{mk(0,0,1,FLU_DIV,1,1,0,0,6'b100010), mk(0,0,1,FLU_ALU,1,1,0,0,6'b000001),
             mk(0,0,1,FLU_ALU,1,1,0,1,6'b000001), mk(0,0,1,FLU_ALU,1,1,0,0,6'b110000),
             mk(1,0,1,FLU_MUL,1,1,0,0,6'b100010), mk(1,0,1,FLU_MUL,1,1,0,1,6'b000000),
             mk(1,0,1,FLU_ALU,1,1,0,0,6'b110000), mk(1,0,0,FLU_ALU,1,1,0,0,6'b100000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL flush cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_after_mul();
    row_t rows [10];
    rows = '{mk(0,0,1,FLU_MUL,1,1,0,0,6'b100010), mk(0,0,1,FLU_DIV,1,1,0,0,6'b000000),
             mk(0,0,1,FLU_DIV,1,1,0,0,6'b100010), mk(0,0,1,FLU_ALU,1,1,0,0,6'b000001),
             mk(0,0,1,FLU_ALU,1,1,1,0,6'b000001), mk(0,0,1,FLU_ALU,1,1,0,0,6'b110000),
             mk(0,0,1,FLU_MUL,1,0,0,0,6'b000000), mk(0,0,1,FLU_CSR,0,1,0,0,6'b000000),
             mk(0,0,1,FLU_CSR,1,1,0,0,6'b100100), mk(0,0,1,FLU_DIV,1,0,0,0,6'b000000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL div_after_mul cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf();
    row_t rows [9];
    logic [31:0] exp_perf;
`ifdef FLU_SCHED_PERF_EN
    exp_perf = 32'd3;
`else
    exp_perf = 32'd0;
`endif
    rows = '{mk(0,1,0,FLU_ALU,1,1,0,0,6'b000000), mk(0,0,1,FLU_DIV,1,1,0,0,6'b100010),
             mk(0,0,1,FLU_ALU,1,1,0,0,6'b000001), mk(0,0,1,FLU_ALU,1,1,0,0,6'b000001),
             mk(0,0,1,FLU_ALU,1,1,1,0,6'b000001), mk(0,0,1,FLU_ALU,1,1,0,0,6'b110000),
             mk(0,0,1,FLU_CSR,0,1,0,0,6'b000000), mk(0,0,1,FLU_CSR,0,1,0,0,6'b000000),
             mk(0,0,0,FLU_ALU,1,1,0,0,6'b100000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL perf cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (perf1 !== exp_perf) begin
      $display("FAIL perf_count got=%0d exp=%0d", perf1, exp_perf); n_err++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_hold();
    row_t rows [4];
    rows = '{mk(0,0,1,FLU_DIV,1,1,0,0,6'b100010), mk(0,1,1,FLU_ALU,1,1,0,0,6'b000001),
             mk(0,1,1,FLU_ALU,1,1,0,0,6'b000000), mk(0,0,0,FLU_ALU,1,1,0,0,6'b100000)};
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      got = sel ? obs2 : obs1; exp_v = expq.pop_front(); n_cmp++;
      if (got !== exp_v) begin $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, got, exp_v); n_err++; end
      if (i == 2) begin
        n_cmp++;
        if (perf1 !== 32'd0) begin $display("FAIL reset_hold_perf got=%0d exp=0", perf1); n_err++; end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; flush = 1'b0; sel = 1'b0; iv = 1'b0; fu = FLU_ALU;
    crdy = 1'b1; mrdy = 1'b1; dd = 1'b0;
    test_reset();
    test_mul_l1();
    test_back_to_back_l2();
    test_div();
    test_flush();
    test_div_after_mul();
    test_perf();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
